l2_mem_responder: RTL and testbench

- Memory-side responder for the L2 cache's slow-memory port. It accepts block read and write requests from one L2 channel (instruction or data; the top level instantiates one per channel).
- Each request completes after a fixed, programmable latency: a one-cycle ready pulse, with read data that stays stable afterwards.
- Used as the synthesizable slow-memory model in block-level and system simulation of the L2.

---
 rtl/l2_mem_responder.sv | 122 ++++++++++++
 tb/tb_l2_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_responder.sv
// Slow-memory responder for one L2 channel: fixed-latency block read/write
// with a one-cycle ready pulse and read data held until the next read.
module l2_mem_responder #(
    parameter int unsigned LATENCY    = 8,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [27:0]       mem_addr,
    input  logic [127:0]      mem_wdata,
    output logic [127:0]      mem_rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_done_cnt,
    output logic [CNT_W-1:0]  wr_done_cnt
);

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CYC_W  = 8;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [CYC_W-1:0] LAST_CNT = CYC_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t               r_state;
    logic [CYC_W-1:0]     r_cnt;
    logic                 r_op_wr;
    logic [DATA_W-1:0]    r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_live_req;
    logic                  w_commit;
    logic                  w_unused_addr;

    // Upper address bits alias onto the same entries.
    assign w_idx         = mem_addr[DEPTH_LOG2-1:0];
    assign w_unused_addr = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

    // Abort check follows only the request type that was latched on entry.
    assign w_live_req = r_op_wr ? mem_write : mem_read;

    // Write commit keys off the latched op: the requester drops mem_write in the ready cycle.
    assign w_commit = (r_state == S_RESP) && r_op_wr;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op_wr     <= 1'b0;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            busy        <= 1'b0;
            rd_done_cnt <= '0;
            wr_done_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    mem_ready <= 1'b0;
                    if (mem_write || mem_read) begin
                        r_op_wr <= mem_write;
                        r_cnt   <= CYC_W'(1);
                        r_state <= S_BUSY;
                        busy    <= 1'b1;
                    end
                end

                S_BUSY: begin
                    if (!w_live_req) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state   <= S_RESP;
                        mem_ready <= 1'b1;
                        if (!r_op_wr) begin
                            mem_rdata <= r_mem[w_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt + CYC_W'(1);
                    end
                end

                S_RESP: begin
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                    if (r_op_wr) begin
                        if (wr_done_cnt != CNT_MAX) begin
                            wr_done_cnt <= wr_done_cnt + CNT_W'(1);
                        end
                    end else begin
                        if (rd_done_cnt != CNT_MAX) begin
                            rd_done_cnt <= rd_done_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench for l2_mem_responder (LATENCY=4): directed requests push
// expected ready cycle and read data; a negedge monitor pops and compares.
module tb_l2_mem_responder;

    localparam int unsigned LAT = 4;

    logic         clk;
    logic         proc_reset_n;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         busy;
    logic [15:0]  rd_done_cnt;
    logic [15:0]  wr_done_cnt;

    l2_mem_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (10),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .rd_done_cnt  (rd_done_cnt),
        .wr_done_cnt  (wr_done_cnt)
    );

    typedef struct {
        int           cyc;
        logic [127:0] rdata;
    } exp_t;

    exp_t         q[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    logic [127:0] model_rd = '0;
    logic [127:0] last_rd = '0;
    logic         chk_next = 1'b0;

    localparam logic [127:0] D1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D0  = 128'hDEAD_BEEF_0000_0000_1111_2222_3333_4444;
    localparam logic [127:0] D12 = 128'h1212_1212_ABAB_ABAB_1212_1212_ABAB_ABAB;
    localparam logic [127:0] D34 = 128'h3434_0000_3434_0000_5656_0000_7878_0000;
    localparam logic [127:0] DAA = {16{8'hAA}};
    localparam logic [127:0] D55 = {16{8'h55}};
    localparam logic [127:0] D11 = {16{8'h11}};
    localparam logic [127:0] D22 = {16{8'h22}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per ready pulse, then checks the hold cycle.
    always @(negedge clk) begin
        exp_t e;
        if (chk_next) begin
            chk("rdata_hold", mem_rdata, last_rd);
            chk_next = 1'b0;
        end
        if (mem_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: at cycle %0d with empty queue", cyc);
            end else begin
                e = q.pop_front();
                chk("ready_cycle", 128'(cyc), 128'(e.cyc));
                chk("ready_rdata", mem_rdata, e.rdata);
                last_rd  = e.rdata;
                chk_next = 1'b1;
            end
        end
    end

    // Issue one request, hold it until ready, drop it inside the ready cycle.
    task automatic req(input logic wr, input logic rd, input logic [27:0] addr,
                       input logic [127:0] wdata, input logic [27:0] first_addr,
                       input logic [127:0] rd_val);
        exp_t e;
        bit   seen;
        @(posedge clk);
        #1;
        mem_write = wr;
        mem_read  = rd;
        mem_addr  = first_addr;
        mem_wdata = wdata;
        if (!wr) model_rd = rd_val;
        e.cyc   = cyc + int'(LAT);
        e.rdata = model_rd;
        q.push_back(e);
        @(posedge clk);
        #1;
        mem_addr = addr;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: addr %h got no ready, expected one", addr);
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    task automatic wr_req(input logic [27:0] addr, input logic [127:0] d, input logic [27:0] first_addr);
        req(1'b1, 1'b0, addr, d, first_addr, '0);
    endtask

    task automatic rd_req(input logic [27:0] addr, input logic [127:0] d);
        req(1'b0, 1'b1, addr, '0, addr, d);
    endtask

    initial begin
        proc_reset_n = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        #12;
        chk("rst_ready", 128'(mem_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_rdata", mem_rdata, '0);
        chk("rst_rdcnt", 128'(rd_done_cnt), 128'(0));
        chk("rst_wrcnt", 128'(wr_done_cnt), 128'(0));
        @(negedge clk);
        proc_reset_n = 1'b1;

        // Write then read
        wr_req(28'h0000005, D1, 28'h0000005);
        rd_req(28'h0000005, D1);
        @(posedge clk);
        #1;
        chk("t1_wrcnt", 128'(wr_done_cnt), 128'(1));
        chk("t1_rdcnt", 128'(rd_done_cnt), 128'(1));

        // Writeback then allocate, transient first-cycle address 0
        wr_req(28'h0000034, D34, 28'h0000034);
        wr_req(28'h0000000, D0, 28'h0000000);
        wr_req(28'h0000012, D12, 28'h0000000);
        rd_req(28'h0000034, D34);
        rd_req(28'h0000012, D12);
        rd_req(28'h0000000, D0);

        // Abort: read of 0x7 dropped in cycle 2
        @(posedge clk);
        #1;
        mem_read = 1'b1;
        mem_addr = 28'h0000007;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_rdcnt", 128'(rd_done_cnt), 128'(4));
        chk("abort_rdata", mem_rdata, D0);

        // Simultaneous read and write behaves as a write
        req(1'b1, 1'b1, 28'h0000009, DAA, 28'h0000009, '0);
        @(posedge clk);
        #1;
        chk("both_wrcnt", 128'(wr_done_cnt), 128'(5));
        chk("both_rdcnt", 128'(rd_done_cnt), 128'(4));
        chk("both_rdata", mem_rdata, D0);
        rd_req(28'h0000009, DAA);

        // Aliasing of upper address bits
        wr_req(28'h0000405, D55, 28'h0000405);
        rd_req(28'h0000005, D55);

        // Reset in cycle 2 of a write to 0x3
        wr_req(28'h0000003, D11, 28'h0000003);
        @(posedge clk);
        #1;
        mem_write = 1'b1;
        mem_addr  = 28'h0000003;
        mem_wdata = D22;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        proc_reset_n = 1'b0;
        #1;
        chk("mrst_ready", 128'(mem_ready), 128'(0));
        chk("mrst_busy", 128'(busy), 128'(0));
        chk("mrst_rdata", mem_rdata, '0);
        mem_write = 1'b0;
        model_rd  = '0;
        @(negedge clk);
        proc_reset_n = 1'b1;
        rd_req(28'h0000003, D11);
        @(posedge clk);
        #1;
        chk("mrst_rdcnt", 128'(rd_done_cnt), 128'(1));
        chk("mrst_wrcnt", 128'(wr_done_cnt), 128'(0));

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 128'(q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
